// File: rtl/lcd_timing_pkg.sv
// Shared timing constants for the 480x272 RGB panel and its reduced simulation variant.
// Also used by the downstream character pixel generator.
package lcd_timing_pkg;

  localparam int unsigned H_ACTIVE = 480;
  localparam int unsigned H_FRONT  = 2;
  localparam int unsigned H_SYNC   = 41;
  localparam int unsigned H_BACK   = 2;
  localparam int unsigned V_ACTIVE = 272;
  localparam int unsigned V_FRONT  = 2;
  localparam int unsigned V_SYNC   = 10;
  localparam int unsigned V_BACK   = 2;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned SCREEN_WIDTH  = H_ACTIVE;
  localparam int unsigned SCREEN_HEIGHT = V_ACTIVE;

  // Reduced geometry so a full frame fits in a short simulation.
  localparam int unsigned SIM_H_ACTIVE = 64;
  localparam int unsigned SIM_H_FRONT  = 2;
  localparam int unsigned SIM_H_SYNC   = 1;
  localparam int unsigned SIM_H_BACK   = 2;
  localparam int unsigned SIM_V_ACTIVE = 32;
  localparam int unsigned SIM_V_FRONT  = 2;
  localparam int unsigned SIM_V_SYNC   = 1;
  localparam int unsigned SIM_V_BACK   = 2;

  localparam int unsigned CLK_DIV      = 10;
  localparam int unsigned PIPE_LATENCY = 4;

  localparam int unsigned POS_X_W = 10;
  localparam int unsigned POS_Y_W = 9;

  typedef struct packed {
    logic               de;
    logic               hsync_n;
    logic               vsync_n;
    logic [POS_X_W-1:0] x;
    logic [POS_Y_W-1:0] y;
  } lcd_timing_t;

  localparam lcd_timing_t TIMING_RST = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                         x: '0, y: '0};

endpackage

// File: rtl/lcd_timing_gen_sync_counter.sv
// Wrap counter 0..TOTAL-1 advancing on en_i; resets to TOTAL-1 so the first
// enabled step lands on 0. Exposes the next value and the wrap strobe combinationally.
module sync_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_next_c_o,
  output logic         wrap_c_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_c;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_c = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        wrap_c = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= LAST;
    else        cnt_q <= cnt_d;
  end

  assign cnt_next_c_o = cnt_d;
  assign wrap_c_o     = wrap_c;

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB panel timing generator: divides clk into lcd_dclk and produces registered
// hsync/vsync/DE, pixel position and line/frame start strobes on each dclk falling edge.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter bit SIM = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [POS_X_W-1:0] pos_x,
  output logic [POS_Y_W-1:0] pos_y,
  output logic               lcd_dclk,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic               lcd_de,
  output logic               frame_start,
  output logic               line_start
);

  localparam int unsigned HA = SIM ? SIM_H_ACTIVE : H_ACTIVE;
  localparam int unsigned HF = SIM ? SIM_H_FRONT  : H_FRONT;
  localparam int unsigned HS = SIM ? SIM_H_SYNC   : H_SYNC;
  localparam int unsigned HB = SIM ? SIM_H_BACK   : H_BACK;
  localparam int unsigned VA = SIM ? SIM_V_ACTIVE : V_ACTIVE;
  localparam int unsigned VF = SIM ? SIM_V_FRONT  : V_FRONT;
  localparam int unsigned VS = SIM ? SIM_V_SYNC   : V_SYNC;
  localparam int unsigned VB = SIM ? SIM_V_BACK   : V_BACK;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  localparam int unsigned PH_W = $clog2(CLK_DIV);
  localparam int unsigned XW   = POS_X_W;
  localparam int unsigned YW   = POS_Y_W;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            dclk_q, dclk_d;
  logic            adv_c;
  logic [XW-1:0]   h_next_c;
  logic [YW-1:0]   v_next_c;
  logic            h_wrap_c, v_wrap_c;
  lcd_timing_t     tim_q, tim_d;
  logic            frame_start_q, frame_start_d;
  logic            line_start_q, line_start_d;

  // Advance edge: phase wraps to 0, which is also the dclk falling edge.
  assign adv_c = (phase_q == PH_W'(CLK_DIV - 1));

  always_comb begin
    phase_d = adv_c ? '0 : phase_q + PH_W'(1);
    dclk_d  = (phase_d >= PH_W'(CLK_DIV / 2));
  end

  sync_counter #(.TOTAL(HT), .W(XW)) u_h_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (adv_c),
    .cnt_next_c_o (h_next_c),
    .wrap_c_o     (h_wrap_c)
  );

  sync_counter #(.TOTAL(VT), .W(YW)) u_v_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (h_wrap_c),
    .cnt_next_c_o (v_next_c),
    .wrap_c_o     (v_wrap_c)
  );

  // Decode the upcoming position; held for a whole dclk period between advance edges.
  always_comb begin
    tim_d         = tim_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (adv_c) begin
      tim_d.de      = (h_next_c < XW'(HA)) && (v_next_c < YW'(VA));
      tim_d.hsync_n = !((h_next_c >= XW'(HA + HF)) && (h_next_c < XW'(HA + HF + HS)));
      tim_d.vsync_n = !((v_next_c >= YW'(VA + VF)) && (v_next_c < YW'(VA + VF + VS)));
      tim_d.x       = tim_d.de ? h_next_c : '0;
      tim_d.y       = tim_d.de ? v_next_c : '0;
      line_start_d  = h_wrap_c;
      frame_start_d = h_wrap_c && v_wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= '0;
      dclk_q        <= 1'b0;
      tim_q         <= TIMING_RST;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      dclk_q        <= dclk_d;
      tim_q         <= tim_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign lcd_dclk    = dclk_q;
  assign lcd_de      = tim_q.de;
  assign lcd_hsync   = tim_q.hsync_n;
  assign lcd_vsync   = tim_q.vsync_n;
  assign pos_x       = tim_q.x;
  assign pos_y       = tim_q.y;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen in its reduced simulation geometry
// (64x32 active, porches 2, syncs 1, CLK_DIV 10).
module tb_lcd_timing_gen;

  localparam int HA = 64, HF = 2, HS = 1, HB = 2, HT = 69;
  localparam int VA = 32, VF = 2, VS = 1, VB = 2, VT = 37;
  localparam int CDIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic       lcd_dclk, lcd_hsync, lcd_vsync, lcd_de, frame_start, line_start;

  lcd_timing_gen #(.SIM(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .lcd_dclk    (lcd_dclk),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_de      (lcd_de),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] pix_f(input logic [9:0] x, input logic [8:0] y);
    return {y, x} ^ 19'h5A5A5;
  endfunction

  // Stand-in for the 4-clk downstream pixel pipeline.
  logic [18:0] pipe [4];
  always @(posedge clk) begin
    pipe[0] <= pix_f(pos_x, pos_y);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end

  int h = 0, v = 0;
  int de_cnt = 0, hs_cnt = 0, hs_first = -1;
  int vs_lines = 0, vs_first = -1, fs_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    de_cnt = 0; hs_cnt = 0; hs_first = -1;
    vs_lines = 0; vs_first = -1; fs_cnt = 0;
  endtask

  // Called at the sample point just after an advance edge presenting (h, v).
  task automatic check_outputs();
    logic       e_de;
    logic [9:0] e_x;
    logic [8:0] e_y;
    e_de = (h < HA) && (v < VA);
    e_x  = e_de ? 10'(h) : 10'd0;
    e_y  = e_de ? 9'(v) : 9'd0;
    check_eq("de",          32'(lcd_de),      32'(e_de));
    check_eq("pos_x",       32'(pos_x),       32'(e_x));
    check_eq("pos_y",       32'(pos_y),       32'(e_y));
    check_eq("hsync",       32'(lcd_hsync),   32'(!(h >= HA + HF && h < HA + HF + HS)));
    check_eq("vsync",       32'(lcd_vsync),   32'(!(v >= VA + VF && v < VA + VF + VS)));
    check_eq("line_start",  32'(line_start),  32'(h == 0));
    check_eq("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
    if (lcd_de) de_cnt++;
    if (!lcd_hsync) begin
      if (hs_cnt == 0) hs_first = h;
      hs_cnt++;
    end
    if (h == 0 && !lcd_vsync) begin
      if (vs_lines == 0) vs_first = v;
      vs_lines++;
    end
    if (frame_start) fs_cnt++;
    if (h == HT - 1) begin
      check_eq("line_de_count", 32'(de_cnt),   32'((v < VA) ? HA : 0));
      check_eq("line_hs_count", 32'(hs_cnt),   32'(HS));
      check_eq("hs_start",      32'(hs_first), 32'(HA + HF));
      de_cnt = 0; hs_cnt = 0; hs_first = -1;
      if (v == VT - 1) begin
        check_eq("frame_vs_lines", 32'(vs_lines), 32'(VS));
        check_eq("vs_start_line",  32'(vs_first), 32'(VA + VF));
        check_eq("frame_fs_count", 32'(fs_cnt),   32'(1));
        vs_lines = 0; vs_first = -1; fs_cnt = 0;
      end
    end
  endtask

  task automatic run_dclks(input int n);
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic       e_de;
    for (int d = 0; d < n; d++) begin
      check_outputs();
      e_de = (h < HA) && (v < VA);
      e_x  = e_de ? 10'(h) : 10'd0;
      e_y  = e_de ? 9'(v) : 9'd0;
      for (int k = 1; k < CDIV; k++) begin
        step();
        if (k == 1) begin
          check_eq("line_start_width",  32'(line_start),  32'(0));
          check_eq("frame_start_width", 32'(frame_start), 32'(0));
        end
        if (k == 4) begin
          check_eq("dclk_low",       32'(lcd_dclk), 32'(0));
          check_eq("pipe_pre_rise",  32'(pipe[3]),  32'(pix_f(e_x, e_y)));
        end
        if (k == 5) begin
          check_eq("dclk_high",      32'(lcd_dclk), 32'(1));
          check_eq("pipe_at_rise",   32'(pipe[3]),  32'(pix_f(e_x, e_y)));
          check_eq("de_at_rise",     32'(lcd_de),   32'(e_de));
        end
      end
      step();
      h++;
      if (h == HT) begin
        h = 0;
        v++;
        if (v == VT) v = 0;
      end
    end
  endtask

  task automatic check_reset_values(input string sfx);
    check_eq({"rst_dclk", sfx},  32'(lcd_dclk),    32'(0));
    check_eq({"rst_hsync", sfx}, 32'(lcd_hsync),   32'(1));
    check_eq({"rst_vsync", sfx}, 32'(lcd_vsync),   32'(1));
    check_eq({"rst_de", sfx},    32'(lcd_de),      32'(0));
    check_eq({"rst_pos_x", sfx}, 32'(pos_x),       32'(0));
    check_eq({"rst_pos_y", sfx}, 32'(pos_y),       32'(0));
    check_eq({"rst_fs", sfx},    32'(frame_start), 32'(0));
    check_eq({"rst_ls", sfx},    32'(line_start),  32'(0));
  endtask

  // From release (at a negedge) through the first advance edge presenting (0,0).
  task automatic release_and_start();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= CDIV; k++) begin
      step();
      if (k < CDIV) begin
        check_eq("pre_adv_dclk", 32'(lcd_dclk),    32'(k >= CDIV / 2));
        check_eq("pre_adv_de",   32'(lcd_de),      32'(0));
        check_eq("pre_adv_fs",   32'(frame_start), 32'(0));
        check_eq("pre_adv_ls",   32'(line_start),  32'(0));
      end else begin
        check_eq("first_adv_dclk", 32'(lcd_dclk), 32'(0));
      end
    end
    h = 0;
    v = 0;
    clear_stats();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("");
    release_and_start();
    // One full frame, ending on (0,0) of the next frame.
    run_dclks(HT * VT);
    // Move to column 40, line 10, then 7 clks into that dclk period.
    run_dclks(HT * 10 + 40);
    check_eq("mid_h_model", 32'(pos_x), 32'(40));
    check_eq("mid_v_model", 32'(pos_y), 32'(10));
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("_held");
    release_and_start();
    run_dclks(HT * 2 + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Upstream neighbour of the character pixel generator.
- Divides the system clock into the RGB panel pixel clock (lcd_dclk) and generates hsync, vsync and DE for the 480x272 panel on the Tang Nano 9k.
- Supplies pos_x/pos_y to the pixel generator. Each position is presented at the lcd_dclk falling edge and held long enough for the 4-clk pixel pipeline to settle before the next lcd_dclk rising edge.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FRONT, 2, front-porch dclks
- H_SYNC, 41, hsync width in dclks
- H_BACK, 2, back-porch dclks
- V_ACTIVE, 272, visible lines
- V_FRONT, 2, front-porch lines
- V_SYNC, 10, vsync width in lines
- V_BACK, 2, back-porch lines
- CLK_DIV, 10, clk cycles per lcd_dclk period; must be even
- PIPE_LATENCY, 4, downstream pixel pipeline depth in clk; requires CLK_DIV/2 >= PIPE_LATENCY+1

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- pos_x  out  10  active-area column; 0 outside active area
- pos_y  out  9  active-area row; 0 outside active area
- lcd_dclk  out  1  panel pixel clock; panel samples on rising edge
- lcd_hsync  out  1  horizontal sync, active low
- lcd_vsync  out  1  vertical sync, active low
- lcd_de  out  1  data enable, high during active pixels
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented
- line_start  out  1  one-clk pulse when column 0 of any line (active or blanking) is presented

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (525); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (286). Requires H_TOTAL <= 1024 and V_TOTAL <= 512.
- Counters:
  - phase: 0..CLK_DIV-1
  - h_cnt: 0..H_TOTAL-1
  - v_cnt: 0..V_TOTAL-1
- Segment order within each line/frame: active, front porch, sync, back porch.
- Reset (async, rst_n=0):
  - phase=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - Outputs: lcd_dclk=0, lcd_hsync=1, lcd_vsync=1, lcd_de=0, pos_x=0, pos_y=0, frame_start=0, line_start=0.
- Phase counter:
  - Increments every clk and wraps CLK_DIV-1 -> 0.
  - lcd_dclk is registered: 0 for phase 0..CLK_DIV/2-1, 1 for phase CLK_DIV/2..CLK_DIV-1.
- Advance edge: the clk edge on which phase wraps to 0, which is also the lcd_dclk falling edge.
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and itself wraps V_TOTAL-1 -> 0.
- Output timing: all timing outputs are registered decodes of the next (h_cnt, v_cnt), updated on the advance edge only and stable for a full dclk period.
  - lcd_de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - lcd_hsync low when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC
  - lcd_vsync low when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, for whole lines
  - pos_x = de ? h : 0
  - pos_y = de ? v : 0
- Pixel alignment: pixel data from the downstream pipeline is valid PIPE_LATENCY clk after the advance edge. lcd_dclk rises at phase CLK_DIV/2, at least 1 clk later, so DE and data are sampled together with no extra delay on de.
- frame_start / line_start:
  - frame_start = 1 for exactly one clk on the advance edge into (0,0).
  - line_start = 1 for exactly one clk on each advance edge into h=0.
  - At (0,0) both pulse on the same edge.
- Reset mid-frame: all state returns to the reset values immediately. After release, the first advance edge (CLK_DIV clks later) presents (0,0) with frame_start.
- No partial frames are ever emitted after reset.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - the panel timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - SCREEN_WIDTH/HEIGHT;
  - the SIM-reduced set: 64x32 active area, all porches 2, syncs 1.
- The pixel generator consumes the same package.
- One sub-module is natural: sync_counter, a parameterized wrap counter with enable and a wrap output. It is instantiated twice (h, v); the phase divider stays inline.

Test Plan:
- Reset release, defaults: first lcd_dclk rise at clk 5 after release; first advance at clk 10; pos=(0,0), de=1, frame_start and line_start both single-clk pulses.
- Line timing:
  - de high for 480 dclks per active line;
  - hsync low for exactly 41 dclks, starting 482 dclks after de rises;
  - line period 525 dclks = 5250 clk.
- Frame timing:
  - vsync low for 10 lines, starting at line 274;
  - frame period 286x5250 = 1,501,500 clk;
  - frame_start exactly once per frame.
- Position values:
  - last active pixel gives pos_x=479, pos_y=271;
  - next dclk gives de=0 with pos_x=0, pos_y=0;
  - blanking lines keep de=0 throughout.
- Alignment: a model pipeline of 4-clk delay fed from pos shows stable data ≥1 clk before every lcd_dclk rise; the data sampled on de-high rises equals f(pos).
- Async reset asserted mid-line (h=200, v=100, phase=7): outputs go to reset values without a clk edge; after release, the frame restarts at (0,0) with frame_start.
